// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared width, funct3 encodings, FSM states and iteration counts for ex_muldiv.
package muldiv_pkg;
  localparam int XLEN = 64;
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;
  localparam logic [6:0] ITER_D    = 7'd64;
  localparam logic [6:0] ITER_W    = 7'd32;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  function automatic logic [XLEN-1:0] wext(input logic w, input logic [XLEN-1:0] x);
    return w ? {{32{x[31]}}, x[31:0]} : x;
  endfunction
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one combinational radix-2 step, shift-add for multiply, restoring shift-subtract for divide.
module muldiv_iter import muldiv_pkg::*; (
  input  logic            div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] m,
  output logic [XLEN-1:0] hi_n,
  output logic [XLEN-1:0] lo_n
);
  logic [XLEN:0] sum, sh, diff;
  assign sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
  assign sh   = {hi, lo[XLEN-1]};
  assign diff = sh - {1'b0, m};
  assign hi_n = div ? (diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0]) : sum[XLEN:1];
  assign lo_n = div ? {lo[XLEN-2:0], ~diff[XLEN]} : {sum[0], lo[XLEN-1:1]};
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV64M multiply/divide unit with pipeline stall and one-cycle done pulse.
// Word variants (op_w) are honoured only when MULDIV_WORD_OPS_EN is defined.
module ex_muldiv import muldiv_pkg::*; (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic            op_w,
  input  logic            flush,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);
  state_t state;
  logic [6:0] cnt;
  logic [2:0] op_q;
  logic word_q, neg_q, sa_q;
  logic [XLEN-1:0] hi, lo, m, hi_n, lo_n;
  logic word_in, a_sgn, b_sgn, sa, sb, div0, ovf;
  logic [XLEN-1:0] a_in, b_in, a_mag, b_mag, min_neg, spec_res, qf, rf, mul_res, fin;
  logic [2*XLEN-1:0] p, pf;
`ifdef MULDIV_WORD_OPS_EN
  assign word_in = op_w;
  assign a_in = word_in ? (op[0] ? {32'b0, rs1_val[31:0]} : {{32{rs1_val[31]}}, rs1_val[31:0]}) : rs1_val;
  assign b_in = word_in ? (op[0] ? {32'b0, rs2_val[31:0]} : {{32{rs2_val[31]}}, rs2_val[31:0]}) : rs2_val;
`else
  logic unused_op_w;
  assign unused_op_w = op_w;
  assign word_in = 1'b0;
  assign a_in = rs1_val;
  assign b_in = rs2_val;
`endif
  assign a_sgn = op[2] ? ~op[0] : (op != OP_MULHU);
  assign b_sgn = op[2] ? ~op[0] : ~op[1];
  assign sa = a_sgn & a_in[XLEN-1];
  assign sb = b_sgn & b_in[XLEN-1];
  assign a_mag = sa ? -a_in : a_in;
  assign b_mag = sb ? -b_in : b_in;
  // Most-negative dividend after extension differs for word ops.
  assign min_neg = word_in ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
  assign div0 = op[2] & (b_in == '0);
  assign ovf = op[2] & ~op[0] & (a_in == min_neg) & (&b_in);
  assign spec_res = wext(word_in, div0 ? (op[1] ? a_in : '1) : (op[1] ? '0 : a_in));
  muldiv_iter u_iter (.div(op_q[2]), .hi(hi), .lo(lo), .m(m), .hi_n(hi_n), .lo_n(lo_n));
  // Word multiplies stop after 32 shifts, leaving the product 32 bits up.
  assign p = {hi_n, lo_n};
  assign pf = neg_q ? -p : p;
  assign qf = neg_q ? -lo_n : lo_n;
  assign rf = sa_q ? -hi_n : hi_n;
  assign mul_res = (op_q == OP_MUL) ? (word_q ? {32'b0, pf[63:32]} : pf[63:0]) : pf[127:64];
  assign fin = wext(word_q, op_q[2] ? (op_q[1] ? rf : qf) : mul_res);
  assign stall = reset_n & (((state == S_IDLE) & start & ~flush) | (state == S_CALC));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt <= '0;
      op_q <= '0;
      word_q <= 1'b0;
      neg_q <= 1'b0;
      sa_q <= 1'b0;
      hi <= '0;
      lo <= '0;
      m <= '0;
      done <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      done <= 1'b0;
      result <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          result <= '0;
          if (start) begin
            op_q <= op;
            word_q <= word_in;
            neg_q <= sa ^ sb;
            sa_q <= sa;
            hi <= '0;
            lo <= op[2] ? (word_in ? {a_mag[31:0], 32'b0} : a_mag) : b_mag;
            m <= op[2] ? b_mag : a_mag;
            cnt <= word_in ? ITER_W : ITER_D;
            if (div0 | ovf) begin
              state <= S_DONE;
              done <= 1'b1;
              result <= spec_res;
            end else state <= S_CALC;
          end
        end
        S_CALC: begin
          hi <= hi_n;
          lo <= lo_n;
          cnt <= cnt - 7'd1;
          if (cnt == 7'd1) begin
            state <= S_DONE;
            done <= 1'b1;
            result <= fin;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done <= 1'b0;
          result <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: table-driven directed checks of ex_muldiv results, latency and stall, plus flush/reset sequences.
module tb_ex_muldiv;
  import muldiv_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, op_w = 1'b0, flush = 1'b0;
  logic [2:0] op = 3'd0;
  logic [63:0] rs1 = '0, rs2 = '0, result;
  logic stall, done;
  int n_cmp = 0, n_err = 0;
  typedef struct {logic [2:0] o; logic w; logic [63:0] a; logic [63:0] b; logic [63:0] r; int lat;} vec_t;
  vec_t v[15];

  ex_muldiv dut (.clk(clk), .reset_n(reset_n), .start(start), .op(op), .op_w(op_w), .flush(flush),
                 .rs1_val(rs1), .rs2_val(rs2), .stall(stall), .done(done), .result(result));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic run(input string name, input logic [2:0] o, input logic w, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] exp, input int lat);
    int n, st;
    op = o; op_w = w; rs1 = a; rs2 = b; start = 1'b1; n = 0; st = 0;
    #1;
    if (stall) st++;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      if (stall) st++;
    end
    chk({name, " latency"}, 64'(n), 64'(lat));
    chk({name, " stall cycles"}, 64'(st), 64'(lat));
    chk({name, " result"}, result, exp);
    chk({name, " stall in done"}, {63'b0, stall}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    chk({name, " idle after done"}, {62'b0, stall, done}, 64'd0);
    chk({name, " result cleared"}, result, 64'd0);
  endtask

  initial begin
    v[0]  = '{OP_MUL,    1'b0, 64'd7,                 -64'sd3,               64'hFFFF_FFFF_FFFF_FFEB, 65};
    v[1]  = '{OP_MULHU,  1'b0, '1,                    '1,                    64'hFFFF_FFFF_FFFF_FFFE, 65};
    v[2]  = '{OP_MULH,   1'b0, '1,                    64'd1,                 '1,                      65};
    v[3]  = '{OP_DIVU,   1'b0, 64'd123,               64'd0,                 '1,                      1};
    v[4]  = '{OP_REMU,   1'b0, 64'd123,               64'd0,                 64'd123,                 1};
    v[5]  = '{OP_DIV,    1'b0, 64'h8000_0000_0000_0000, '1,                  64'h8000_0000_0000_0000, 1};
    v[6]  = '{OP_REM,    1'b0, 64'h8000_0000_0000_0000, '1,                  64'd0,                   1};
    v[7]  = '{OP_REM,    1'b0, -64'sd7,               64'd2,                 '1,                      65};
    v[8]  = '{OP_DIV,    1'b0, -64'sd7,               64'd2,                 -64'sd3,                 65};
    v[9]  = '{OP_MULHSU, 1'b0, '1,                    64'd2,                 '1,                      65};
    v[10] = '{OP_DIVU,   1'b0, 64'd100,               64'd7,                 64'd14,                  65};
    v[11] = '{OP_REM,    1'b0, 64'd7,                 -64'sd2,               64'd1,                   65};
    v[12] = '{OP_MUL,    1'b0, 64'h1_0000_0001,       64'h1_0000_0001,       64'h2_0000_0001,         65};
    v[13] = '{OP_DIV,    1'b0, 64'd5,                 64'd0,                 '1,                      1};
    v[14] = '{OP_REM,    1'b0, -64'sd5,               64'd0,                 -64'sd5,                 1};
    start = 1'b1;
    #1;
    chk("reset outputs", {stall, done, result[61:0]}, 64'd0);
    chk("reset result", result, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 15; i++) run($sformatf("vec%0d", i), v[i].o, v[i].w, v[i].a, v[i].b, v[i].r, v[i].lat);
`ifdef MULDIV_WORD_OPS_EN
    run("divw", OP_DIV, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
`else
    run("op_w ignored", OP_DIV, 1'b1, -64'sd7, 64'd2, -64'sd3, 65);
`endif
    // flush coincident with start must not launch
    op = OP_DIVU; rs1 = 64'd9; rs2 = 64'd3; start = 1'b1; flush = 1'b1;
    #1;
    chk("flush+start stall", {63'b0, stall}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    #1;
    chk("flush+start no launch", {62'b0, stall, done}, 64'd0);
    // flush in CALC cycle 10
    @(posedge clk); #1;
    op = OP_MUL; rs1 = 64'd3; rs2 = 64'd5; start = 1'b1;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
    flush = 1'b1;
    #1;
    chk("calc stall at flush", {63'b0, stall}, 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    #1;
    chk("stall after flush", {63'b0, stall}, 64'd0);
    begin
      int d = 0;
      for (int i = 0; i < 70; i++) begin @(posedge clk); #1; if (done || stall) d++; end
      chk("no done after flush", 64'(d), 64'd0);
    end
    run("after flush", OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    // asynchronous reset in cycle 20 of a DIV
    op = OP_DIV; rs1 = -64'sd7; rs2 = 64'd2; start = 1'b1;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; end
    chk("stall before reset", {63'b0, stall}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mid-calc reset stall/done", {62'b0, stall, done}, 64'd0);
    chk("mid-calc reset result", result, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle after reset", {62'b0, stall, done}, 64'd0);
    run("after reset", OP_MUL, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
